// File: rtl/i2c_reg_slave_if.sv
// -----------------------------------------------------------------------------
// i2c_reg_slave_if
// Pin-side bundle of the I2C register target.
//   scl_i  : SCL pin value as seen on the board (asynchronous to clk)
//   sda_i  : SDA pin value as seen on the board (asynchronous to clk)
//   sda_oe : 1 = target pulls SDA low, 0 = target releases SDA
// The master modport is the board/bench side, the slave modport the target.
// -----------------------------------------------------------------------------
interface i2c_reg_slave_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport master (
    output scl_i,
    output sda_i,
    input  sda_oe
  );

  modport slave (
    input  scl_i,
    input  sda_i,
    output sda_oe
  );
endinterface

// File: rtl/i2c_reg_slave.sv
// -----------------------------------------------------------------------------
// i2c_reg_slave
// I2C target with a byte-wide register file exposed in parallel to fabric.
// SCL/SDA are oversampled on clk; START, repeated START and STOP are decoded.
// Write: addr+W, pointer byte, then any number of data bytes (auto-increment).
// Read : addr+R, bytes from the current pointer (auto-increment).
// The pointer wraps at NUM_REGS-1 and is kept between transactions.
//
// Ports
//   clk       : system clock, at least 16x SCL
//   rst       : asynchronous active-high reset
//   bus       : pin bundle (scl_i, sda_i in; sda_oe out, 1 = pull SDA low)
//   reg_q     : flattened register file, register k at [8k+7:8k]
//   wr_strobe : one-cycle pulse when a register is written
//   wr_index  : index of the written register, valid with wr_strobe
//   busy      : high from an address match until STOP/START/ignore
// -----------------------------------------------------------------------------
module i2c_reg_slave #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         NUM_REGS    = 8,
  parameter logic [7:0] REG_INIT    = 8'h00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  i2c_reg_slave_if.slave              bus,
  output logic [NUM_REGS*8-1:0]       reg_q,
  output logic                        wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0] wr_index,
  output logic                        busy
);

  localparam int PW = $clog2(NUM_REGS);
  localparam int SW = $clog2(SYNC_STAGES + 2);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } state_t;

  // Input conditioning
  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic [SW-1:0]          settle_q;

  logic scl_s;
  logic sda_s;
  logic armed_s;
  logic scl_rise_s;
  logic scl_fall_s;
  logic start_s;
  logic stop_s;

  // Protocol state
  state_t        state_q;
  logic [2:0]    bit_cnt_q;
  logic [6:0]    shift_q;
  logic [7:0]    data_q;
  logic          rw_q;
  logic          ack_rise_q;
  logic          mack_q;
  logic [PW-1:0] ptr_q;
  logic [7:0]    regs_q [NUM_REGS];

  // Registered outputs
  logic          sda_oe_q;
  logic          busy_q;
  logic          wr_strobe_q;
  logic [PW-1:0] wr_index_q;

  logic [7:0]    rx_byte_s;
  logic [PW-1:0] ptr_next_s;
  logic          ptr_ok_s;
  logic [7:0]    rd_byte_s;

  assign scl_s   = scl_sync_q[SYNC_STAGES-1];
  assign sda_s   = sda_sync_q[SYNC_STAGES-1];
  // Edges are masked until the pipeline holds real pin values after reset,
  // so a bus caught mid-transfer cannot fake a START or STOP.
  assign armed_s = (settle_q == SW'(SYNC_STAGES + 1));

  assign scl_rise_s = armed_s &  scl_s & ~scl_prev_q;
  assign scl_fall_s = armed_s & ~scl_s &  scl_prev_q;
  assign start_s    = armed_s & scl_s & scl_prev_q &  sda_prev_q & ~sda_s;
  assign stop_s     = armed_s & scl_s & scl_prev_q & ~sda_prev_q &  sda_s;

  // Byte completed by the bit sampled on the current SCL rise.
  assign rx_byte_s  = {shift_q, sda_s};
  assign ptr_next_s = (ptr_q == PW'(NUM_REGS - 1)) ? {PW{1'b0}} : (ptr_q + PW'(1));
  assign ptr_ok_s   = ({1'b0, rx_byte_s} < 9'(NUM_REGS));
  assign rd_byte_s  = regs_q[ptr_q];

  assign bus.sda_oe = sda_oe_q;
  assign busy       = busy_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_index   = wr_index_q;

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_flat
      assign reg_q[8*g +: 8] = regs_q[g];
    end
  endgenerate

  // Synchronise both pins and keep one previous sample for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= {SYNC_STAGES{1'b1}};
      sda_sync_q <= {SYNC_STAGES{1'b1}};
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      settle_q   <= {SW{1'b0}};
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      if (!armed_s) begin
        settle_q <= settle_q + SW'(1);
      end else begin
        settle_q <= settle_q;
      end
    end
  end

  // Protocol FSM, register file and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      data_q      <= 8'd0;
      rw_q        <= 1'b0;
      ack_rise_q  <= 1'b0;
      mack_q      <= 1'b0;
      ptr_q       <= {PW{1'b0}};
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= {PW{1'b0}};
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= REG_INIT;
      end
    end else begin
      wr_strobe_q <= 1'b0;
      if (start_s) begin
        // Repeated or fresh START aborts whatever byte was in flight.
        state_q    <= ST_ADDR;
        bit_cnt_q  <= 3'd0;
        ack_rise_q <= 1'b0;
        sda_oe_q   <= 1'b0;
        busy_q     <= 1'b0;
      end else if (stop_s) begin
        state_q    <= ST_IDLE;
        bit_cnt_q  <= 3'd0;
        ack_rise_q <= 1'b0;
        sda_oe_q   <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
          end

          ST_ADDR: begin
            if (scl_rise_s) begin
              shift_q <= rx_byte_s[6:0];
              if (bit_cnt_q == 3'd7) begin
                bit_cnt_q  <= 3'd0;
                ack_rise_q <= 1'b0;
                if (rx_byte_s[7:1] == DEV_ADDR) begin
                  rw_q    <= rx_byte_s[0];
                  busy_q  <= 1'b1;
                  state_q <= ST_ADDR_ACK;
                end else begin
                  state_q <= ST_IGNORE;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end

          // Shared ACK slot: drive on the fall after the 8th rise, wait for
          // the 9th rise, then move on at the 9th fall.
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall_s) begin
              if (!ack_rise_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                ack_rise_q <= 1'b0;
                bit_cnt_q  <= 3'd0;
                if (state_q == ST_ADDR_ACK && rw_q) begin
                  // First read byte is snapshotted here; its MSB goes out now.
                  state_q  <= ST_RDATA;
                  data_q   <= rd_byte_s;
                  sda_oe_q <= ~rd_byte_s[7];
                end else if (state_q == ST_ADDR_ACK) begin
                  state_q  <= ST_PTR;
                  sda_oe_q <= 1'b0;
                end else begin
                  state_q  <= ST_WDATA;
                  sda_oe_q <= 1'b0;
                end
              end
            end else if (scl_rise_s) begin
              ack_rise_q <= 1'b1;
            end
          end

          ST_PTR: begin
            if (scl_rise_s) begin
              shift_q <= rx_byte_s[6:0];
              if (bit_cnt_q == 3'd7) begin
                bit_cnt_q  <= 3'd0;
                ack_rise_q <= 1'b0;
                if (ptr_ok_s) begin
                  ptr_q   <= PW'(rx_byte_s);
                  state_q <= ST_PTR_ACK;
                end else begin
                  state_q <= ST_IGNORE;
                  busy_q  <= 1'b0;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end

          ST_WDATA: begin
            if (scl_rise_s) begin
              shift_q <= rx_byte_s[6:0];
              if (bit_cnt_q == 3'd7) begin
                bit_cnt_q     <= 3'd0;
                ack_rise_q    <= 1'b0;
                regs_q[ptr_q] <= rx_byte_s;
                wr_strobe_q   <= 1'b1;
                wr_index_q    <= ptr_q;
                ptr_q         <= ptr_next_s;
                state_q       <= ST_WDATA_ACK;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
          end

          ST_RDATA: begin
            if (scl_rise_s) begin
              if (bit_cnt_q == 3'd7) begin
                bit_cnt_q  <= 3'd0;
                ack_rise_q <= 1'b0;
                ptr_q      <= ptr_next_s;
                state_q    <= ST_RACK;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end else if (scl_fall_s) begin
              sda_oe_q <= ~data_q[6];
              data_q   <= {data_q[6:0], 1'b0};
            end
          end

          ST_RACK: begin
            if (scl_fall_s) begin
              if (!ack_rise_q) begin
                sda_oe_q <= 1'b0;
              end else if (mack_q) begin
                ack_rise_q <= 1'b0;
                bit_cnt_q  <= 3'd0;
                state_q    <= ST_RDATA;
                data_q     <= rd_byte_s;
                sda_oe_q   <= ~rd_byte_s[7];
              end else begin
                ack_rise_q <= 1'b0;
                state_q    <= ST_IGNORE;
                sda_oe_q   <= 1'b0;
                busy_q     <= 1'b0;
              end
            end else if (scl_rise_s) begin
              ack_rise_q <= 1'b1;
              mack_q     <= ~sda_s;
            end
          end

          ST_IGNORE: begin
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
          end

          default: begin
            state_q  <= ST_IDLE;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
